stream_arbiter: RTL

- Round-robin scheduler that shares the single multi-stream filter channel between NR_STREAMS independent sample sources.
- Sits in front of the filter in place of a fixed-order mux. It grants one requesting stream for a burst of BURST_LEN samples, forwards them with their stream index, then re-arbitrates.
- Guarantees bursts are never interleaved, so per-stream filter state stays coherent.

---
 rtl/stream_arbiter_pkg.sv | 23 ++
 rtl/stream_arbiter_if.sv | 31 +++
 rtl/stream_arbiter_rr_picker.sv | 27 ++
 rtl/stream_arbiter.sv | 111 +++++++++++
 4 files changed

// File: rtl/stream_arbiter_pkg.sv
// Shared types and helpers for the round-robin stream arbiter.
// Included by the interface, picker and top.
package stream_arbiter_pkg;

  localparam int DEF_DWIDTH     = 16;
  localparam int DEF_NR_STREAMS = 4;
  localparam int DEF_NR_LOG     = 2;
  localparam int DEF_BURST_LEN  = 8;
  localparam int DEF_CNT_W      = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  function automatic int slice_lo(
    input int idx,
    input int dw
  );
    return idx * dw;
  endfunction

endpackage

// File: rtl/stream_arbiter_if.sv
// Stream-side and filter-side handshake bundle of the arbiter.
// The slave modport is the arbiter, the master drives the sources and sink.
interface stream_arbiter_if
  import stream_arbiter_pkg::*;
#(
  parameter int DWIDTH         = DEF_DWIDTH,
  parameter int NR_STREAMS     = DEF_NR_STREAMS,
  parameter int NR_STREAMS_LOG = DEF_NR_LOG
);

  logic [NR_STREAMS-1:0]         stream_en;
  logic [NR_STREAMS-1:0]         in_req;
  logic [NR_STREAMS-1:0]         in_ack;
  logic [0:NR_STREAMS*DWIDTH-1]  in_data;
  logic                          out_req;
  logic                          out_ack;
  logic [DWIDTH-1:0]             out_data;
  logic [NR_STREAMS_LOG-1:0]     out_stream;
  logic                          busy;

  modport master (
    output stream_en, in_req, in_data, out_ack,
    input  in_ack, out_req, out_data, out_stream, busy
  );

  modport slave (
    input  stream_en, in_req, in_data, out_ack,
    output in_ack, out_req, out_data, out_stream, busy
  );

endinterface

// File: rtl/stream_arbiter_rr_picker.sv
// Rotate-priority encoder: first set mask bit at or after ptr, wrapping.
// Works for any stream count, not only powers of two.
module rr_picker #(
  parameter int N   = 4,
  parameter int LOG = 2
) (
  input  logic [N-1:0]   mask_i,
  input  logic [LOG-1:0] ptr_i,
  output logic           found_o,
  output logic [LOG-1:0] idx_o
);

  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    // Walk from farthest to nearest so the nearest hit wins.
    for (int k = N - 1; k >= 0; k--) begin
      int j;
      j = (int'(ptr_i) + k) % N;
      if (mask_i[j]) begin
        found_o = 1'b1;
        idx_o   = LOG'(j);
      end
    end
  end

endmodule

// File: rtl/stream_arbiter.sv
// Round-robin burst arbiter sharing one filter channel between streams.
// A grant holds the channel for BURST_LEN transfers, then re-arbitrates.
module stream_arbiter
  import stream_arbiter_pkg::*;
#(
  parameter int DWIDTH         = DEF_DWIDTH,
  parameter int NR_STREAMS     = DEF_NR_STREAMS,
  parameter int NR_STREAMS_LOG = DEF_NR_LOG,
  parameter int BURST_LEN      = DEF_BURST_LEN,
  parameter int CNT_W          = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  stream_arbiter_if.slave  bus
);

  state_t                    state_q, state_d;
  logic [NR_STREAMS_LOG-1:0] rr_ptr_q, rr_ptr_d;
  logic [NR_STREAMS_LOG-1:0] grant_q, grant_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;

  logic [NR_STREAMS-1:0]     elig;
  logic                      pick_found;
  logic [NR_STREAMS_LOG-1:0] pick_idx;
  logic                      grant_req;
  logic                      xfer;
  logic [DWIDTH-1:0]         sel_data;

  assign elig = bus.in_req & bus.stream_en;

  rr_picker #(
    .N   (NR_STREAMS),
    .LOG (NR_STREAMS_LOG)
  ) u_picker (
    .mask_i  (elig),
    .ptr_i   (rr_ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  assign grant_req = bus.in_req[grant_q];
  assign xfer      = (state_q == ST_BURST) & grant_req & bus.out_ack;

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NR_STREAMS; i++) begin
      if (grant_q == NR_STREAMS_LOG'(i))
        sel_data = bus.in_data[slice_lo(i, DWIDTH) +: DWIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          cnt_d   = '0;
          state_d = ST_BURST;
        end
      end
      ST_BURST: begin
        if (xfer) begin
          if (cnt_q == CNT_W'(BURST_LEN - 1)) begin
            state_d  = ST_IDLE;
            cnt_d    = '0;
            rr_ptr_d = (grant_q == NR_STREAMS_LOG'(NR_STREAMS - 1))
                     ? '0
                     : grant_q + NR_STREAMS_LOG'(1);
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.out_req    = 1'b0;
    bus.out_data   = '0;
    bus.out_stream = '0;
    bus.busy       = 1'b0;
    bus.in_ack     = '0;
    if (state_q == ST_BURST) begin
      bus.busy            = 1'b1;
      bus.out_stream      = grant_q;
      bus.out_req         = grant_req;
      bus.out_data        = sel_data;
      bus.in_ack[grant_q] = grant_req & bus.out_ack;
    end
  end

endmodule
